ibex_xif_instr_mem_responder: RTL and testbench
===============================================

# ibex_xif_instr_mem_responder

Responder end of the core's instruction fetch bus: accepts req/gnt/rvalid transactions issued by the prefetch buffer and services them from a single-port synchronous instruction SRAM. Tracks up to `MaxOutstanding` granted-but-unanswered requests, buffers read data in an in-order response FIFO, and flags out-of-range addresses with a bus error. Sits between the fetch stage and the instruction memory macro in both the integrated system and the fetch-path testbench. Two stall inputs let a bench or arbiter hold off grants and responses independently.

## Interface
- `MemAddrWidth`, 14: SRAM word-address width; window size is 2^MemAddrWidth words.
- `BaseAddr`, 32'h0010_0000: byte base address of the window; word aligned.
- `MaxOutstanding`, 2: maximum requests granted but not yet answered; legal range 1..8.

- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input 32: byte address; bits [1:0] ignored.
- `instr_gnt_o` output 1: request accepted this cycle.
- `instr_rvalid_o` output 1: response valid.
- `instr_rdata_o` output 32: response data.
- `instr_err_o` output 1: response error, qualified by `instr_rvalid_o`.
- `gnt_stall_i` input 1: suppresses `instr_gnt_o` while high.
- `resp_stall_i` input 1: suppresses `instr_rvalid_o` while high.
- `mem_req_o` output 1: SRAM read enable.
- `mem_addr_o` output MemAddrWidth: SRAM word address.
- `mem_rdata_i` input 32: SRAM read data, valid the cycle after `mem_req_o`.
- `busy_o` output 1: any request in flight or buffered.

## Operation
- Grant: `instr_gnt_o = instr_req_i & ~gnt_stall_i & (outstanding < MaxOutstanding)`, evaluated combinationally. A pop in the same cycle frees one credit in that cycle.
- `outstanding` counter, width $clog2(MaxOutstanding+1).
  - Increments on grant and decrements on `instr_rvalid_o`.
  - Grant and pop in the same cycle leave it unchanged.
  - It never exceeds `MaxOutstanding` and never underflows.
- Decode: word offset = `instr_addr_i[31:2] - BaseAddr[31:2]`, computed with 30-bit modular subtraction. The access is in range iff offset < 2^MemAddrWidth, so addresses below the base wrap to a large offset and are out of range.
- In-range grant:
  - `mem_req_o = 1` and `mem_addr_o = offset[MemAddrWidth-1:0]`, in the same cycle.
  - A 1-bit in-flight flag, with the error bit clear, is registered for the next cycle.
- Out-of-range grant:
  - `mem_req_o = 0`.
  - The in-flight flag is registered with the error bit set.
- Capture: in the cycle after a grant, the FIFO writes {`mem_rdata_i`, err=0} for an in-range access, or {32'h0, err=1} for an out-of-range one.
- Response FIFO:
  - Depth `MaxOutstanding`, 33 bits wide.
  - Read and write pointers wrap modulo depth; full and empty are taken from the entry count.
  - The credit rule guarantees no write when full.
- Response: `instr_rvalid_o = ~fifo_empty & ~resp_stall_i`. `instr_rdata_o` and `instr_err_o` show the FIFO head, and are zero whenever the FIFO is empty. A head is popped on every cycle `instr_rvalid_o` is high.
- Ordering: responses are returned strictly in grant order, one per grant.
- `busy_o = (outstanding != 0)`.
- Reset (asynchronous, any time, including mid-burst):
  - Counter, pointers, FIFO count, in-flight flag and error bit clear. Any data still in flight is dropped.
  - `instr_rvalid_o`, `instr_err_o`, `instr_rdata_o`, `mem_req_o`, `busy_o` and `mem_addr_o` are 0.
  - `instr_gnt_o` follows `instr_req_i & ~gnt_stall_i`, since the counter is 0.
  - FIFO data storage itself needs no reset.

## Timing
- Grant in cycle N leads to the SRAM access in N, FIFO write at the end of N+1, and earliest `instr_rvalid_o` in N+2.
- A sustained request stream at `MaxOutstanding`=2 with no stalls settles to grants in N, N+1, then one grant per cycle from N+2 onward, matched by one rvalid per cycle.
- `resp_stall_i` high holds the FIFO. Grants continue until `outstanding` = `MaxOutstanding`; `instr_gnt_o` then drops until pops resume.
- `gnt_stall_i` does not affect responses that are already buffered or in flight.
- `instr_req_i` dropped after a grant does not cancel the response; the initiator is responsible for discarding unwanted data.

## Test plan
- Back-to-back fetch: SRAM word 0 = 32'hAAAA_0001, word 1 = 32'hAAAA_0002. Request 32'h0010_0000 then 32'h0010_0004 in consecutive cycles. Required: gnt in N and N+1, rvalid in N+2 and N+3 carrying data in that order, err=0.
- Credit limit: `resp_stall_i`=1, req held for 4 cycles. Required: exactly 2 gnts, then gnt=0 with `busy_o`=1. Release the stall: rvalid in 2 consecutive cycles, and gnt reasserts in the first pop cycle.
- Out-of-range: request 32'h000F_FFFC (below base) and 32'h0010_0000 + 2^16 (above the window). Required: both granted, `mem_req_o`=0, rvalid with err=1 and rdata=32'h0.
- Mixed order: requests in-range, out-of-range, in-range. Required: responses in order, err pattern 0,1,0.
- Grant stall: `gnt_stall_i`=1 for 3 cycles with req high. Required: no gnt and no `mem_req_o`. Previously buffered responses still drain on schedule.
- Reset mid-op: assert `rst_ni`=0 with 2 requests outstanding. Required: rvalid, `busy_o` and `mem_req_o` go 0 immediately. After release, a new request is granted in the first cycle and its rvalid arrives 2 cycles later, with no stale responses.

Source files
------------

// File: rtl/ibex_xif_instr_mem_responder.sv
// Instruction fetch bus responder: grants req/gnt/rvalid fetches against a
// single-port synchronous SRAM window, tracks outstanding credits and returns
// responses in grant order through a small FIFO.
module ibex_xif_instr_mem_responder #(
    parameter int unsigned MemAddrWidth   = 14,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [31:0]             instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    gnt_stall_i,
    input  logic                    resp_stall_i,
    output logic                    mem_req_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    input  logic [31:0]             mem_rdata_i,
    output logic                    busy_o
);

    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned DataW = 33;
    localparam int unsigned OffW  = 30;

    logic [CntW-1:0]  outstanding_q, outstanding_d;
    logic [CntW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_err_q;
    logic [DataW-1:0] fifo_mem [MaxOutstanding];

    logic [OffW-1:0]  word_offset;
    logic             in_range;
    logic             credit_avail;
    logic             gnt;
    logic             pop;
    logic             push;
    logic             fifo_empty;
    logic [DataW-1:0] head;
    logic [DataW-1:0] wr_data;

    // Window decode; addresses below the base wrap to a large offset
    assign word_offset = instr_addr_i[31:2] - BaseAddr[31:2];
    assign in_range    = (word_offset >> MemAddrWidth) == OffW'(0);

    // Credit check; a pop this cycle frees a slot immediately
    assign fifo_empty   = (fifo_cnt_q == CntW'(0));
    assign pop          = ~fifo_empty & ~resp_stall_i;
    assign credit_avail = (outstanding_q < CntW'(MaxOutstanding)) | pop;
    assign gnt          = instr_req_i & ~gnt_stall_i & credit_avail;
    assign instr_gnt_o  = gnt;

    // SRAM access issued in the grant cycle; held off while in reset
    assign mem_req_o  = gnt & in_range & rst_ni;
    assign mem_addr_o = mem_req_o ? word_offset[MemAddrWidth-1:0] : '0;

    // Capture path: SRAM data or an error beat, one cycle after the grant
    assign push    = inflight_q;
    assign wr_data = inflight_err_q ? {32'h0, 1'b1} : {mem_rdata_i, 1'b0};

    // Response head; forced to zero when nothing is buffered
    assign head           = fifo_mem[rd_ptr_q];
    assign instr_rvalid_o = pop;
    assign instr_rdata_o  = fifo_empty ? 32'h0 : head[DataW-1:1];
    assign instr_err_o    = fifo_empty ? 1'b0 : head[0];
    assign busy_o         = (outstanding_q != CntW'(0));

    // Next-state for credit counter, FIFO count and pointers
    always_comb begin
        outstanding_d = outstanding_q;
        fifo_cnt_d    = fifo_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (gnt && !pop) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!gnt && pop) begin
            outstanding_d = outstanding_q - CntW'(1);
        end

        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? PtrW'(0) : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? PtrW'(0) : rd_ptr_q + PtrW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q  <= '0;
            fifo_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            outstanding_q  <= outstanding_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= gnt;
            inflight_err_q <= gnt & ~in_range;
        end
    end

    // Response storage; contents are qualified by the count, so no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_ibex_xif_instr_mem_responder.sv
// Directed self-checking bench for the instruction fetch responder.
module tb_ibex_xif_instr_mem_responder;

    localparam logic [31:0] Base = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        gnt_stall;
    logic        resp_stall;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_xif_instr_mem_responder #(
        .MemAddrWidth  (14),
        .BaseAddr      (Base),
        .MaxOutstanding(2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o (rdata),
        .instr_err_o   (err),
        .gnt_stall_i   (gnt_stall),
        .resp_stall_i  (resp_stall),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy)
    );

    // SRAM model: word k holds 32'hAAAA_0001 + k, one-cycle read latency
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= 32'hAAAA_0001 + 32'(mem_addr);
    end

    // Drive one cycle's request inputs, then settle before sampling
    task automatic cyc(input logic r, input logic [31:0] a);
        @(negedge clk);
        req  = r;
        addr = a;
        #1;
    endtask

    // Flags below are {gnt, mem_req, rvalid, err, busy}
    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; addr = Base; gnt_stall = 1'b0; resp_stall = 1'b0;
        #3;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        checks++; if (mem_addr !== 14'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, 14'h0); end
        req = 1'b1; #1;
        checks++; if ({gnt, mem_req} !== 2'b10) begin failures++; $display("FAIL reset_gnt_follows_req got=%b exp=%b", {gnt, mem_req}, 2'b10); end
        gnt_stall = 1'b1; #1;
        checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt_stall got=%b exp=%b", gnt, 1'b0); end
        @(negedge clk);
        req = 1'b0; gnt_stall = 1'b0; rst_n = 1'b1;
        cyc(1'b0, Base);
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11000 || mem_addr !== 14'h0) begin failures++; $display("FAIL b2b_c0 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, mem_addr, 5'b11000, 14'h0); end
        cyc(1'b1, Base + 32'h4);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11001 || mem_addr !== 14'h1) begin failures++; $display("FAIL b2b_c1 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, mem_addr, 5'b11001, 14'h1); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0001) begin failures++; $display("FAIL b2b_c2 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0001); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0002) begin failures++; $display("FAIL b2b_c3 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0002); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000 || rdata !== 32'h0) begin failures++; $display("FAIL b2b_idle got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00000, 32'h0); end
    endtask

    task automatic test_credit_limit();
        logic [4:0] exp_flags [4] = '{5'b11000, 5'b11001, 5'b00001, 5'b00001};
        int gnt_count = 0;
        resp_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, Base + 32'h8);
            if (gnt === 1'b1) gnt_count++;
            checks++; if ({gnt, mem_req, rvalid, err, busy} !== exp_flags[i]) begin failures++; $display("FAIL credit_c%0d got=%b exp=%b", i, {gnt, mem_req, rvalid, err, busy}, exp_flags[i]); end
        end
        checks++; if (gnt_count !== 2) begin failures++; $display("FAIL credit_gnt_count got=%0d exp=%0d", gnt_count, 2); end
        @(negedge clk); resp_stall = 1'b0; #1;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11101 || rdata !== 32'hAAAA_0003) begin failures++; $display("FAIL credit_pop0 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b11101, 32'hAAAA_0003); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0003) begin failures++; $display("FAIL credit_pop1 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0003); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0003) begin failures++; $display("FAIL credit_pop2 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0003); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL credit_idle got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
    endtask

    task automatic test_out_of_range();
        cyc(1'b1, 32'h000F_FFFC);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b10000) begin failures++; $display("FAIL oor_below got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b10000); end
        cyc(1'b1, Base + 32'h0001_0000);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b10001) begin failures++; $display("FAIL oor_above got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b10001); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00111 || rdata !== 32'h0) begin failures++; $display("FAIL oor_resp0 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00111, 32'h0); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00111 || rdata !== 32'h0) begin failures++; $display("FAIL oor_resp1 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00111, 32'h0); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL oor_idle got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
    endtask

    task automatic test_mixed_order();
        cyc(1'b1, Base + 32'h0000_FFFC);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11000 || mem_addr !== 14'h3FFF) begin failures++; $display("FAIL mixed_c0 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, mem_addr, 5'b11000, 14'h3FFF); end
        cyc(1'b1, Base + 32'h0001_0000);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b10001) begin failures++; $display("FAIL mixed_c1 got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b10001); end
        cyc(1'b1, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11101 || rdata !== 32'hAAAA_4000 || mem_addr !== 14'h0) begin failures++; $display("FAIL mixed_c2 got=%b/%h/%h exp=%b/%h/%h", {gnt, mem_req, rvalid, err, busy}, rdata, mem_addr, 5'b11101, 32'hAAAA_4000, 14'h0); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00111 || rdata !== 32'h0) begin failures++; $display("FAIL mixed_c3 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00111, 32'h0); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0001) begin failures++; $display("FAIL mixed_c4 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0001); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL mixed_idle got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
    endtask

    task automatic test_grant_stall();
        logic [4:0]  exp_flags [3] = '{5'b00101, 5'b00101, 5'b00000};
        logic [31:0] exp_data  [3] = '{32'hAAAA_0002, 32'hAAAA_0003, 32'h0};
        cyc(1'b1, Base + 32'h4);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11000) begin failures++; $display("FAIL gstall_c0 got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b11000); end
        cyc(1'b1, Base + 32'h8);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11001) begin failures++; $display("FAIL gstall_c1 got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b11001); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            gnt_stall = 1'b1; req = 1'b1; addr = Base;
            #1;
            checks++; if ({gnt, mem_req, rvalid, err, busy} !== exp_flags[i] || rdata !== exp_data[i]) begin failures++; $display("FAIL gstall_s%0d got=%b/%h exp=%b/%h", i, {gnt, mem_req, rvalid, err, busy}, rdata, exp_flags[i], exp_data[i]); end
        end
        @(negedge clk); gnt_stall = 1'b0; req = 1'b0; #1;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL gstall_idle got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
    endtask

    task automatic test_reset_mid_op();
        cyc(1'b1, Base);
        cyc(1'b1, Base + 32'h4);
        checks++; if ({gnt, busy} !== 2'b11) begin failures++; $display("FAIL rstmid_setup got=%b exp=%b", {gnt, busy}, 2'b11); end
        @(negedge clk); rst_n = 1'b0; req = 1'b1; addr = Base; #1;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b10000 || rdata !== 32'h0 || mem_addr !== 14'h0) begin failures++; $display("FAIL rstmid_assert got=%b/%h/%h exp=%b/%h/%h", {gnt, mem_req, rvalid, err, busy}, rdata, mem_addr, 5'b10000, 32'h0, 14'h0); end
        @(negedge clk); #1;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b10000) begin failures++; $display("FAIL rstmid_hold got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b10000); end
        @(negedge clk); rst_n = 1'b1; req = 1'b1; addr = Base + 32'hC; #1;
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b11000 || mem_addr !== 14'h3) begin failures++; $display("FAIL rstmid_c0 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, mem_addr, 5'b11000, 14'h3); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00001) begin failures++; $display("FAIL rstmid_c1 got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00001); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00101 || rdata !== 32'hAAAA_0004) begin failures++; $display("FAIL rstmid_c2 got=%b/%h exp=%b/%h", {gnt, mem_req, rvalid, err, busy}, rdata, 5'b00101, 32'hAAAA_0004); end
        cyc(1'b0, Base);
        checks++; if ({gnt, mem_req, rvalid, err, busy} !== 5'b00000) begin failures++; $display("FAIL rstmid_idle got=%b exp=%b", {gnt, mem_req, rvalid, err, busy}, 5'b00000); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_credit_limit();
        test_out_of_range();
        test_mixed_order();
        test_grant_stall();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound in case the schedule ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
